// File: rtl/fifo_bank_p.sv
// Bank of four independent synchronous FIFOs feeding the arbiter, with a shared
// write bus, a single registered read bus, and per-FIFO status/error flags.
module fifo_bank_p #(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [3:0]            push,
  input  logic [3:0]            pop,
  output logic [DATA_WIDTH-1:0] fifo_out,
  output logic                  valid_out,
  output logic [3:0]            empty,
  output logic [3:0]            full,
  output logic [3:0]            almost_full,
  output logic [3:0]            almost_empty,
  output logic [3:0]            error
);

  localparam int NF    = 4;
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [NF][DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q [NF];
  logic [ADDR_WIDTH-1:0] wr_ptr_d [NF];
  logic [ADDR_WIDTH-1:0] rd_ptr_q [NF];
  logic [ADDR_WIDTH-1:0] rd_ptr_d [NF];
  logic [CNT_W-1:0]      count_q  [NF];
  logic [CNT_W-1:0]      count_d  [NF];

  logic [DATA_WIDTH-1:0] fifo_out_q, fifo_out_d;
  logic                  valid_q, valid_d;
  logic [3:0]            error_q, error_d;

  logic                  push_oh, pop_oh;
  logic [3:0]            push_acc, pop_acc;

  // Status flags are pure decodes of the registered counts.
  always_comb begin
    empty        = '0;
    full         = '0;
    almost_full  = '0;
    almost_empty = '0;
    for (int i = 0; i < NF; i++) begin
      empty[i]        = (count_q[i] == '0);
      full[i]         = (count_q[i] == DEPTH_C);
      almost_full[i]  = (count_q[i] >= AF_C);
      almost_empty[i] = (count_q[i] <= AE_C);
    end
  end

  // Multi-bit strobes are illegal and cause every flagged FIFO to reject.
  always_comb begin
    push_oh = (push != 4'b0000) && ((push & (push - 4'd1)) == 4'b0000);
    pop_oh  = (pop  != 4'b0000) && ((pop  & (pop  - 4'd1)) == 4'b0000);
  end

  always_comb begin
    push_acc   = '0;
    pop_acc    = '0;
    error_d    = error_q;
    fifo_out_d = fifo_out_q;
    valid_d    = 1'b0;
    for (int i = 0; i < NF; i++) begin
      // A pop on a full FIFO frees the slot the same-cycle push will use.
      pop_acc[i]  = pop[i] & pop_oh & ~empty[i];
      push_acc[i] = push[i] & push_oh & (~full[i] | pop_acc[i]);

      if (push[i] && !push_acc[i]) error_d[i] = 1'b1;
      if (pop[i]  && !pop_acc[i])  error_d[i] = 1'b1;

      wr_ptr_d[i] = push_acc[i] ? wr_ptr_q[i] + ADDR_WIDTH'(1) : wr_ptr_q[i];
      rd_ptr_d[i] = pop_acc[i]  ? rd_ptr_q[i] + ADDR_WIDTH'(1) : rd_ptr_q[i];
      count_d[i]  = count_q[i] + CNT_W'(push_acc[i]) - CNT_W'(pop_acc[i]);

      if (pop_acc[i]) begin
        fifo_out_d = mem_q[i][rd_ptr_q[i]];
        valid_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NF; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      fifo_out_q <= '0;
      valid_q    <= 1'b0;
      error_q    <= '0;
    end else begin
      for (int i = 0; i < NF; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        count_q[i]  <= count_d[i];
      end
      fifo_out_q <= fifo_out_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
    end
  end

  // Storage is never cleared; only pointers/counts define what is live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NF; i++) begin
      if (!reset && push_acc[i]) mem_q[i][wr_ptr_q[i]] <= data_in;
    end
  end

  assign fifo_out  = fifo_out_q;
  assign valid_out = valid_q;
  assign error     = error_q;

endmodule

// File: doc/fifo_bank_p.md
Name: fifo_bank_p

Overview:
- Bank of four independent synchronous FIFOs (P0..P3) sitting directly upstream of the 4-input arbiter.
- Shared 12-bit write bus and per-FIFO push lines; per-FIFO pop lines come from the arbiter.
- One registered, muxed read bus (fifo_out) carries the popped word.
- Exports per-FIFO empty and almost_full flags; the arbiter uses empty to pick the next class and skip empty FIFOs.

Parameters:
DATA_WIDTH, 12, word width; bits [11:10] carry the destination class used by the arbiter
DEPTH, 8, words per FIFO; power of two
ADDR_WIDTH, 3, log2(DEPTH)
AF_THRESH, 6, almost_full asserted when count >= AF_THRESH
AE_THRESH, 1, almost_empty asserted when count <= AE_THRESH

Ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  synchronous, active-high
data_in  input  DATA_WIDTH  shared write data
push  input  4  per-FIFO write strobe; one-hot or zero
pop  input  4  per-FIFO read strobe from arbiter; one-hot or zero
fifo_out  output  DATA_WIDTH  registered read data of the last accepted pop
valid_out  output  1  high for the single cycle fifo_out carries a newly popped word
empty  output  4  count==0 per FIFO
full  output  4  count==DEPTH per FIFO
almost_full  output  4  count>=AF_THRESH per FIFO
almost_empty  output  4  count<=AE_THRESH per FIFO
error  output  4  sticky per-FIFO overflow/underflow/illegal-strobe flag

Behaviour:
- Reset (synchronous, active-high; sampled at posedge clk):
  - All read/write pointers and counts go to 0.
  - fifo_out=0, valid_out=0, error=4'b0000.
  - empty=4'b1111, full=0, almost_full=0, almost_empty=4'b1111.
  - Memory contents are not cleared.
  - Reset asserted mid-operation discards all stored words at that edge. Any push or pop in the same cycle is ignored.
- Storage: each FIFO is a DEPTH x DATA_WIDTH array with ADDR_WIDTH-bit pointers that wrap naturally (7 -> 0). count is ADDR_WIDTH+1 bits, range 0..DEPTH.
- Push to FIFO i: accepted when push[i]=1, push is one-hot, and (full[i]=0 or an accepted pop[i] occurs in the same cycle). mem[wr_ptr]<=data_in, wr_ptr++.
- Pop from FIFO i: accepted when pop[i]=1, pop is one-hot, and empty[i]=0.
  - rd_ptr++.
  - fifo_out<=mem[rd_ptr] at the same edge; data visible the cycle after pop is sampled (latency 1).
  - valid_out<=1 for that one cycle only.
- No accepted pop: fifo_out holds its last value, valid_out<=0.
- Simultaneous push and pop on the same FIFO:
  - Non-empty: both accepted, count unchanged.
  - Full: both accepted, count stays DEPTH.
  - Empty: push accepted, pop rejected (no bypass), error[i] set.
- Push and pop on different FIFOs in the same cycle are fully independent.
- Overflow (push[i] while full[i], no pop[i]): write dropped, error[i]<=1.
- Underflow (pop[i] while empty[i]): no pointer change, fifo_out holds, valid_out=0, error[i]<=1.
- Illegal strobes:
  - More than one push bit set: all pushes dropped; error set for every FIFO whose push bit is set.
  - More than one pop bit set: handled the same way.
- error bits are sticky until reset.
- Flags: combinational decode of the registered counts. They reflect a push/pop in the cycle after its edge.
  - almost_full rises at the edge where count reaches 6.
  - empty falls one cycle after the first push.
- AF_THRESH gives the downstream two words of slack at DEPTH=8. The arbiter must stop popping into a destination whose almost_full is high.

Test Plan:
1. Reset 2 cycles, push 12'h096 into P0 for 4 cycles -> empty=4'b1110 after first push edge; count0=4; almost_full=0; error=0.
2. Pop P0 4 consecutive cycles -> fifo_out=12'h096 with valid_out=1 on each of the 4 following cycles; empty[0]=1 after the 4th; a 5th pop sets error[0]=1, fifo_out holds 12'h096, valid_out=0.
3. Push 12'h8F0,12'hDA0,12'hD1E,12'hE29,12'hE29,12'hF29 into P2 -> almost_full[2] rises on the 6th edge. Two more pushes -> full[2]=1. A 9th push drops data and sets error[2]. Popping all 8 returns the words in push order, including pointer wrap.
4. P1 full, push[1]&pop[1] same cycle -> count stays 8, fifo_out=oldest word, new word stored at tail; P1 empty with push&pop -> word stored, empty[1]=0 next cycle, error[1]=1, valid_out=0.
5. push=4'b0011 with data 12'hABC -> neither FIFO written, error=4'b0011. pop=4'b1100 -> no pops, error[3:2] set.
6. Fill P3 with 5 words, assert reset for 1 cycle while pop[3]=1 -> next cycle empty=4'b1111, fifo_out=0, valid_out=0, error=0. A push then pop returns only the new word.
